// File: rtl/alu_result_accumulator_27bits_18bits_if.sv
// Bus between the 27|18-bit SIMD ALU and its P-register/accumulator stage.
// master: ALU side (drives sum, carries, frame control); slave: accumulator.
interface alu_result_accumulator_27bits_18bits_if #(
    parameter int unsigned WIDTH_LO = 27,
    parameter int unsigned WIDTH_HI = 18,
    parameter int unsigned CNT_W    = 8
);
    localparam int unsigned WIDTH = WIDTH_LO + WIDTH_HI;

    logic             in_valid;
    logic             clear_acc;
    logic             USE_SIMD;
    logic [CNT_W-1:0] acc_len;
    logic [WIDTH-1:0] S;
    logic [3:0]       result_SIMD_carry_out;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] pattern_mask;
    logic [WIDTH-1:0] W_fb;
    logic [WIDTH-1:0] P;
    logic             out_valid;
    logic             out_last;
    logic [1:0]       overflow;
    logic [CNT_W-1:0] beat_cnt;
    logic             pattern_match;

    modport master (
        output in_valid, clear_acc, USE_SIMD, acc_len, S, result_SIMD_carry_out,
               pattern, pattern_mask,
        input  W_fb, P, out_valid, out_last, overflow, beat_cnt, pattern_match
    );

    modport slave (
        input  in_valid, clear_acc, USE_SIMD, acc_len, S, result_SIMD_carry_out,
               pattern, pattern_mask,
        output W_fb, P, out_valid, out_last, overflow, beat_cnt, pattern_match
    );
endinterface

// File: rtl/alu_result_accumulator_27bits_18bits.sv
// P-register/accumulator behind the 27|18 SIMD ALU: frames of acc_len beats, W feedback, sticky overflow.
// Optional pattern detect on each accepted beat when ALU_ACC_PATTERN_DETECT_EN is defined.
module alu_result_accumulator_27bits_18bits #(
    parameter int unsigned WIDTH_LO = 27,
    parameter int unsigned WIDTH_HI = 18,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    alu_result_accumulator_27bits_18bits_if.slave bus
);
    localparam int unsigned WIDTH = WIDTH_LO + WIDTH_HI;

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic [1:0]       ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             match_q, match_d;

    logic [CNT_W-1:0] eff_len_c;
    logic             beat_mode_c;
    logic [1:0]       beat_ovf_c;
    logic             match_c;

    // Low-segment carry only counts in two-lane mode; mode is frozen at frame start.
    always_comb begin
        eff_len_c   = (bus.acc_len == '0) ? CNT_W'(1) : bus.acc_len;
        beat_mode_c = (state_q == IDLE) ? bus.USE_SIMD : mode_q;
        beat_ovf_c  = {bus.result_SIMD_carry_out[3],
                       beat_mode_c & bus.result_SIMD_carry_out[1]};
    end

`ifdef ALU_ACC_PATTERN_DETECT_EN
    assign match_c = &((bus.S ~^ bus.pattern) | bus.pattern_mask);
`else
    logic unused_pattern;
    assign match_c        = 1'b0;
    assign unused_pattern = ^{bus.pattern, bus.pattern_mask};
`endif

    logic unused_carry;
    assign unused_carry = bus.result_SIMD_carry_out[0] ^ bus.result_SIMD_carry_out[2];

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        match_d = match_q;

        if (bus.clear_acc) begin
            state_d = IDLE;
            p_d     = '0;
            cnt_d   = '0;
            ovf_d   = '0;
            match_d = 1'b0;
        end else if (bus.in_valid) begin
            p_d     = bus.S;
            match_d = match_c;
            if (state_q == IDLE) begin
                mode_d = bus.USE_SIMD;
                ovf_d  = beat_ovf_c;
                len_d  = eff_len_c;
                if (eff_len_c == CNT_W'(1)) begin
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end
            end else begin
                ovf_d = ovf_q | beat_ovf_c;
                // cnt_q counts beats already taken, so this is the frame's last beat.
                if (cnt_q == len_q - CNT_W'(1)) begin
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            cnt_q   <= '0;
            len_q   <= CNT_W'(1);
            mode_q  <= 1'b0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    // Feedback is taken straight from the P register so the ALU loop closes in one cycle.
    assign bus.W_fb          = (state_q == ACCUM) ? p_q : '0;
    assign bus.P             = p_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_last      = valid_q;
    assign bus.overflow      = ovf_q;
    assign bus.beat_cnt      = cnt_q;
    assign bus.pattern_match = match_q;
endmodule

// File: tb/tb_alu_result_accumulator_27bits_18bits.sv
// Self-checking bench for the ALU result accumulator; expected frame results flow through a scoreboard queue.
module tb_alu_result_accumulator_27bits_18bits;
    localparam int unsigned WL = 27;
    localparam int unsigned WH = 18;
    localparam int unsigned CW = 8;
    localparam int unsigned W  = WL + WH;

`ifdef ALU_ACC_PATTERN_DETECT_EN
    localparam logic PD = 1'b1;
`else
    localparam logic PD = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] p;
        logic [1:0]   ovf;
        logic         match;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_result_accumulator_27bits_18bits_if #(.WIDTH_LO(WL), .WIDTH_HI(WH), .CNT_W(CW)) bus ();

    alu_result_accumulator_27bits_18bits #(.WIDTH_LO(WL), .WIDTH_HI(WH), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One accepted beat; returns at posedge+1 with in_valid dropped again.
    task automatic beat(input logic [W-1:0] s, input logic [3:0] c, input logic simd,
                        input logic [CW-1:0] len);
        bus.in_valid              = 1'b1;
        bus.S                     = s;
        bus.result_SIMD_carry_out = c;
        bus.USE_SIMD              = simd;
        bus.acc_len               = len;
        @(posedge clk);
        #1;
        bus.in_valid              = 1'b0;
        bus.result_SIMD_carry_out = 4'b0000;
    endtask

    task automatic push(input logic [W-1:0] p, input logic [1:0] ovf, input logic match);
        exp_t x;
        x.p     = p;
        x.ovf   = ovf;
        x.match = match;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.P, bus.W_fb, bus.out_valid, bus.out_last, bus.overflow, bus.beat_cnt, bus.pattern_match} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: P=%h W_fb=%h ov=%b ol=%b ovf=%b cnt=%0d pm=%b required all 0",
                     bus.P, bus.W_fb, bus.out_valid, bus.out_last, bus.overflow, bus.beat_cnt, bus.pattern_match);
        end
        beat(W'(100), 4'b0000, 1'b0, CW'(4));
        beat(W'(200), 4'b1000, 1'b0, CW'(4));
        n_cmp++;
        if ({bus.W_fb, bus.beat_cnt, bus.overflow} !== {W'(200), CW'(2), 2'b10}) begin
            n_bad++;
            $display("FAIL reset_midframe_setup: W_fb=%0d cnt=%0d ovf=%b required 200 2 10",
                     bus.W_fb, bus.beat_cnt, bus.overflow);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.P, bus.W_fb, bus.out_valid, bus.out_last, bus.overflow, bus.beat_cnt, bus.pattern_match} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: P=%h W_fb=%h ov=%b ovf=%b cnt=%0d required all 0",
                     bus.P, bus.W_fb, bus.out_valid, bus.overflow, bus.beat_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        push(W'(7), 2'b00, 1'b0);
        beat(W'(7), 4'b0000, 1'b0, CW'(1));
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL reset_newframe_valid: out_valid=%b required 1", bus.out_valid);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({bus.P, bus.overflow, bus.pattern_match, bus.out_last} !== {e.p, e.ovf, e.match, 1'b1}) begin
                n_bad++;
                $display("FAIL reset_newframe_data: P=%0d ovf=%b pm=%b last=%b required %0d %b %b 1",
                         bus.P, bus.overflow, bus.pattern_match, bus.out_last, e.p, e.ovf, e.match);
            end
        end
    endtask

    task automatic test_len1();
        push(W'(5), 2'b00, 1'b0);
        beat(W'(5), 4'b0000, 1'b0, CW'(1));
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL len1_valid: out_valid=%b required 1", bus.out_valid);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({bus.P, bus.out_last, bus.beat_cnt, bus.W_fb} !== {e.p, 1'b1, CW'(0), W'(0)}) begin
                n_bad++;
                $display("FAIL len1_data: P=%0d last=%b cnt=%0d W_fb=%0d required %0d 1 0 0",
                         bus.P, bus.out_last, bus.beat_cnt, bus.W_fb, e.p);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.P} !== {1'b0, W'(5)}) begin
            n_bad++;
            $display("FAIL len1_pulse_hold: out_valid=%b P=%0d required 0 5", bus.out_valid, bus.P);
        end
    endtask

    task automatic test_accum3();
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (bus.W_fb !== W'(10 * (k - 1))) begin
                n_bad++;
                $display("FAIL accum_wfb_beat%0d: W_fb=%0d required %0d", k, bus.W_fb, 10 * (k - 1));
            end
            if (k == 3) push(W'(30), 2'b00, 1'b0);
            beat(bus.W_fb + W'(10), 4'b0000, 1'b0, CW'(3));
            if (k < 3) begin
                n_cmp++;
                if ({bus.out_valid, bus.P, bus.beat_cnt} !== {1'b0, W'(10 * k), CW'(k)}) begin
                    n_bad++;
                    $display("FAIL accum_beat%0d: ov=%b P=%0d cnt=%0d required 0 %0d %0d",
                             k, bus.out_valid, bus.P, bus.beat_cnt, 10 * k, k);
                end
            end
            if (k == 1) begin
                repeat (2) @(posedge clk);
                #1;
                n_cmp++;
                if ({bus.W_fb, bus.beat_cnt, bus.out_valid} !== {W'(10), CW'(1), 1'b0}) begin
                    n_bad++;
                    $display("FAIL accum_hold: W_fb=%0d cnt=%0d ov=%b required 10 1 0",
                             bus.W_fb, bus.beat_cnt, bus.out_valid);
                end
            end
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL accum_valid: out_valid=%b required 1", bus.out_valid);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({bus.P, bus.out_last, bus.beat_cnt, bus.W_fb} !== {e.p, 1'b1, CW'(0), W'(0)}) begin
                n_bad++;
                $display("FAIL accum_data: P=%0d last=%b cnt=%0d W_fb=%0d required %0d 1 0 0",
                         bus.P, bus.out_last, bus.beat_cnt, bus.W_fb, e.p);
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0]  car [10];
        logic        sim [10];
        logic [CW-1:0] len [10];
        logic        last [10];
        logic [1:0]  eovf [10];
        // frame A: simd len2; B: len1 clears; C: non-SIMD ignores low carry; D: mode frozen; E: sticky 3-beat
        car  = '{4'b0010, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
        sim  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        len  = '{CW'(2), CW'(2), CW'(1), CW'(1), CW'(2), CW'(2), CW'(3), CW'(3), CW'(3), CW'(3)};
        last = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        eovf = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
        for (int i = 0; i < 9; i++) begin
            if (last[i]) push(W'(i + 1), eovf[i], 1'b0);
            beat(W'(i + 1), car[i], sim[i], len[i]);
            n_cmp++;
            if (bus.out_valid !== last[i]) begin
                n_bad++;
                $display("FAIL ovf_valid_%0d: out_valid=%b required %b", i, bus.out_valid, last[i]);
            end else if (last[i] && sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.P, bus.overflow, bus.out_last} !== {e.p, e.ovf, 1'b1}) begin
                    n_bad++;
                    $display("FAIL ovf_data_%0d: P=%0d ovf=%b last=%b required %0d %b 1",
                             i, bus.P, bus.overflow, bus.out_last, e.p, e.ovf);
                end
            end
        end
    endtask

    task automatic test_clear();
        beat(W'(1), 4'b1000, 1'b0, CW'(4));
        bus.clear_acc = 1'b1;
        beat(W'(2), 4'b0000, 1'b0, CW'(4));
        bus.clear_acc = 1'b0;
        n_cmp++;
        if ({bus.out_valid, bus.P, bus.beat_cnt, bus.overflow, bus.W_fb} !== '0) begin
            n_bad++;
            $display("FAIL clear_state: ov=%b P=%0d cnt=%0d ovf=%b W_fb=%0d required all 0",
                     bus.out_valid, bus.P, bus.beat_cnt, bus.overflow, bus.W_fb);
        end
        beat(W'(3), 4'b0000, 1'b0, CW'(2));
        push(W'(9), 2'b00, 1'b0);
        beat(W'(9), 4'b0000, 1'b0, CW'(2));
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL clear_refill_valid: out_valid=%b required 1", bus.out_valid);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({bus.P, bus.overflow, bus.beat_cnt} !== {e.p, e.ovf, CW'(0)}) begin
                n_bad++;
                $display("FAIL clear_refill_data: P=%0d ovf=%b cnt=%0d required %0d %b 0",
                         bus.P, bus.overflow, bus.beat_cnt, e.p, e.ovf);
            end
        end
    endtask

    task automatic test_pattern();
        logic [W-1:0] s    [3];
        logic [W-1:0] mask [3];
        logic         em   [3];
        s    = '{W'(45'h1F), W'(45'h1E), W'(45'h1E)};
        mask = '{W'(0), W'(0), W'(1)};
        em   = '{PD, 1'b0, PD};
        bus.pattern = W'(45'h1F);
        for (int i = 0; i < 3; i++) begin
            bus.pattern_mask = mask[i];
            push(s[i], 2'b00, em[i]);
            beat(s[i], 4'b0000, 1'b0, CW'(1));
            n_cmp++;
            if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL pattern_valid_%0d: out_valid=%b required 1", i, bus.out_valid);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.P, bus.pattern_match} !== {e.p, e.match}) begin
                    n_bad++;
                    $display("FAIL pattern_match_%0d: P=%h pm=%b required %h %b",
                             i, bus.P, bus.pattern_match, e.p, e.match);
                end
            end
        end
        bus.pattern      = '0;
        bus.pattern_mask = '0;
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1;
        bus.acc_len  = '0;
        bus.USE_SIMD = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.S = W'(40 + k);
            push(W'(40 + k), 2'b00, 1'b0);
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL b2b_valid_%0d: out_valid=%b required 1", k, bus.out_valid);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.P, bus.beat_cnt, bus.W_fb} !== {e.p, CW'(0), W'(0)}) begin
                    n_bad++;
                    $display("FAIL b2b_data_%0d: P=%0d cnt=%0d W_fb=%0d required %0d 0 0",
                             k, bus.P, bus.beat_cnt, bus.W_fb, e.p);
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                     = 1'b1;
        bus.in_valid              = 1'b0;
        bus.clear_acc             = 1'b0;
        bus.USE_SIMD              = 1'b0;
        bus.acc_len               = '0;
        bus.S                     = '0;
        bus.result_SIMD_carry_out = '0;
        bus.pattern               = '0;
        bus.pattern_mask          = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_len1();
        test_accum3();
        test_overflow();
        test_clear();
        test_pattern();
        test_back_to_back();

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
